// File: rtl/prog_sequencer.sv
// Instruction-issue sequencer for the 4-bit core: buffers a short program
// written by the host and replays it onto instruc/enable with fixed
// setup / pulse / gap timing. Single-shot or looping playback, with stop.
module prog_sequencer #(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 2,
  parameter int GAP_CYC   = 2
) (
  input  logic          clk,
  input  logic          clear_n,
  input  logic          wr_en,
  input  logic [4:0]    wr_data,
  input  logic          flush,
  input  logic          start,
  input  logic          loop,
  input  logic          stop,
  output logic          busy,
  output logic          done,
  output logic          full,
  output logic [AW:0]   count,
  output logic [4:0]    instruc,
  output logic          enable
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [7:0]    SETUP_LAST = 8'(SETUP_CYC - 1);
  localparam logic [7:0]    PULSE_LAST = 8'(PULSE_CYC - 1);
  localparam logic [7:0]    GAP_LAST   = 8'(GAP_CYC - 1);
  localparam logic [AW:0]   DEPTH_V    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  state_t          state_q, state_d;
  logic [7:0]      ph_q, ph_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   rd_ptr_nxt;
  logic [AW:0]     count_d;
  logic [4:0]      instruc_d;
  logic            enable_d, busy_d, done_d, full_d;
  logic            loop_q, loop_d;
  logic            stop_q, stop_d;
  logic            wr_fire;
  logic            last_entry;

  logic [4:0]      mem [DEPTH];

  assign rd_ptr_nxt = rd_ptr_q + PTR_ONE;
  assign last_entry = ({1'b0, rd_ptr_q} == (count - CNT_ONE));

  // Program buffer: write-only from the host side, no reset needed since
  // count gates every read.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[count[AW-1:0]] <= wr_data;
    end
  end

  // State and all registered outputs.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q  <= S_IDLE;
      ph_q     <= '0;
      rd_ptr_q <= '0;
      count    <= '0;
      instruc  <= '0;
      enable   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      full     <= 1'b0;
      loop_q   <= 1'b0;
      stop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      rd_ptr_q <= rd_ptr_d;
      count    <= count_d;
      instruc  <= instruc_d;
      enable   <= enable_d;
      busy     <= busy_d;
      done     <= done_d;
      full     <= full_d;
      loop_q   <= loop_d;
      stop_q   <= stop_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state so that
  // they are registered yet line up with the state they describe.
  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count;
    instruc_d = instruc;
    loop_d    = loop_q;
    stop_d    = stop_q;
    wr_fire   = 1'b0;

    case (state_q)
      S_IDLE: begin
        ph_d = '0;
        if (start && (count != '0)) begin
          rd_ptr_d  = '0;
          instruc_d = mem[0];
          loop_d    = loop;
          stop_d    = 1'b0;
          state_d   = S_SETUP;
        end else if (flush) begin
          count_d = '0;
        end else if (wr_en && !full) begin
          wr_fire = 1'b1;
          count_d = count + CNT_ONE;
        end
      end

      S_SETUP: begin
        if (stop) begin
          // Abort before the strobe ever rises for this entry.
          ph_d    = '0;
          state_d = S_DONE;
        end else if (ph_q == SETUP_LAST) begin
          ph_d    = '0;
          state_d = S_PULSE;
        end else begin
          ph_d = ph_q + 8'd1;
        end
      end

      S_PULSE: begin
        if (stop) begin
          stop_d = 1'b1;
        end
        if (ph_q == PULSE_LAST) begin
          ph_d    = '0;
          state_d = S_GAP;
        end else begin
          ph_d = ph_q + 8'd1;
        end
      end

      S_GAP: begin
        if (stop) begin
          stop_d = 1'b1;
        end
        if (ph_q == GAP_LAST) begin
          ph_d = '0;
          // A stop seen on this same final gap cycle also ends playback.
          if (stop_q || stop) begin
            state_d = S_DONE;
          end else if (last_entry) begin
            if (loop_q) begin
              rd_ptr_d  = '0;
              instruc_d = mem[0];
              state_d   = S_SETUP;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            rd_ptr_d  = rd_ptr_nxt;
            instruc_d = mem[rd_ptr_nxt];
            state_d   = S_SETUP;
          end
        end else begin
          ph_d = ph_q + 8'd1;
        end
      end

      S_DONE: begin
        ph_d      = '0;
        instruc_d = '0;
        state_d   = S_IDLE;
      end

      default: begin
        ph_d    = '0;
        state_d = S_IDLE;
      end
    endcase

    enable_d = (state_d == S_PULSE);
    busy_d   = (state_d == S_SETUP) || (state_d == S_PULSE) || (state_d == S_GAP);
    done_d   = (state_d == S_DONE);
    full_d   = (count_d == DEPTH_V);
  end

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
- Instruction-issue controller for the 4-bit core (fourbits_top_tt04).
- Host loads a short program of 5-bit instructions into an internal buffer, then pulses start.
- Block replays the program to the core's `instruc`/`enable` inputs with fixed setup/pulse/gap timing, so benches and the top level no longer hand-sequence `enable`.
- Supports single-shot and loop playback, plus graceful stop.

Parameters:
- DEPTH, 16, program buffer entries (power of 2).
- AW, 4, buffer address width, log2(DEPTH).
- SETUP_CYC, 2, cycles `instruc` is stable before `enable` rises (>=1).
- PULSE_CYC, 2, cycles `enable` is held high (>=1).
- GAP_CYC, 2, cycles `enable` is low after the pulse, before the next instruction (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- clear_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write `wr_data` into the buffer at the next free slot (IDLE only).
- wr_data  in  5  instruction word to load.
- flush  in  1  empty the buffer: count:=0 (IDLE only).
- start  in  1  begin playback (IDLE only, count>0).
- loop  in  1  sampled at start; 1 = restart from entry 0 after the last entry.
- stop  in  1  request end of playback.
- busy  out  1  high in SETUP/PULSE/GAP.
- done  out  1  one-cycle pulse when playback ends.
- full  out  1  count==DEPTH.
- count  out  AW+1  number of loaded instructions.
- instruc  out  5  instruction to the core.
- enable  out  1  core enable strobe.

Behaviour:
- Reset (async, clear_n=0):
  - state=IDLE; count=0; rd_ptr=0; phase counter=0.
  - instruc=0, enable=0, busy=0, done=0, full=0, loop_q=0, stop_q=0.
  - Buffer contents are not reset; they are irrelevant because count=0.
- States: IDLE, SETUP, PULSE, GAP, DONE. All outputs are registered.
- IDLE:
  - wr_en with !full: buf[count]<=wr_data, count++.
  - wr_en when full: ignored, count unchanged.
  - flush: count<=0. If flush and wr_en arrive in the same cycle, flush wins.
  - start with count>0: rd_ptr<=0, instruc<=buf[0], loop_q<=loop, stop_q<=0, go to SETUP.
  - start with count==0: ignored.
  - In IDLE, start takes priority over a same-cycle wr_en (the write is dropped).
- SETUP: enable=0, instruc held. After SETUP_CYC cycles go to PULSE.
- PULSE: enable=1 for exactly PULSE_CYC cycles, then go to GAP.
- GAP: enable=0 for GAP_CYC cycles. On the last cycle:
  - If stop_q: go to DONE.
  - Else if rd_ptr==count-1 and loop_q: rd_ptr<=0, instruc<=buf[0], go to SETUP.
  - Else if rd_ptr==count-1: go to DONE.
  - Else: rd_ptr++, instruc<=buf[rd_ptr+1], go to SETUP.
- DONE: done=1 for one cycle, instruc<=0, then go to IDLE.
- Timing: start accepted at edge T.
  - enable is high for cycles T+SETUP_CYC .. T+SETUP_CYC+PULSE_CYC-1.
  - Per-instruction period P = SETUP_CYC+PULSE_CYC+GAP_CYC (6 with defaults).
  - For N instructions, done is high in cycle T+N*P.
- stop while busy:
  - Sampled in SETUP: abort immediately. enable never rises for that entry; go to DONE next cycle.
  - Sampled in PULSE or GAP: set stop_q. The pulse is never truncated; finish the gap, then go to DONE.
- wr_en and flush while busy or in DONE: ignored. start while busy: ignored.
- Reset mid-pulse: enable drops asynchronously; the program is lost (count=0).
- count width AW+1, so count==DEPTH is representable. Pointers never exceed count-1.

Test Plan:
- Load 00000, 01101, 01000; start with loop=0 at edge T:
  - instruc sequence is 00000, 01101, 01000.
  - Three 2-cycle enable pulses rise at T+2, T+8, T+14.
  - done high at T+18; then instruc=0, busy=0, count=3.
- Write 17 words: full=1 after the 16th; the 17th is ignored; count=16. Then flush gives count=0 and full=0.
- start with count=0: remains IDLE, busy=0, enable never rises, no done.
- Load 2 words, loop=1, start:
  - Pulses alternate buf[0]/buf[1] for at least 5 pulses.
  - stop asserted in PULSE of pulse 5: that pulse lasts the full 2 cycles; done 2 cycles after the pulse ends; no 6th pulse.
- stop asserted during SETUP of the first instruction: enable never goes high; done the following cycle.
- clear_n=0 while enable=1: enable, busy and count drop to 0 immediately, before the next clock edge. After release, start is ignored until the program is reloaded.
